// File: rtl/bram_reader_pkg.sv
// Shared constants and state encoding for the BRAM stream reader.
// Optional feature macro: BRAM_READER_LAST_EN (adds m_last on the stream).
package bram_reader_pkg;

    localparam int unsigned DEFAULT_DW = 16;
    localparam int unsigned DEFAULT_AW = 8;
    localparam int unsigned SKID_DEPTH = 2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        StIdle  = S_IDLE,
        StRun   = S_RUN,
        StDrain = S_DRAIN
    } state_e;

endpackage

// File: rtl/bram_rd_skid.sv
// Two-entry FIFO holding RAM read data until the stream consumer takes it.
// With BRAM_READER_LAST_EN the caller widens W to carry the last-beat flag.
module bram_rd_skid
    import bram_reader_pkg::*;
#(
    parameter int unsigned W = DEFAULT_DW
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [1:0]   occ,
    output logic [W-1:0] head_data,
    output logic         head_valid
);

    logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
    logic [1:0]   occ_q, occ_d, occ_pop;
    logic         pop_ok;

    assign pop_ok     = pop && (occ_q != 2'd0);
    assign occ        = occ_q;
    assign head_data  = e0_q;
    assign head_valid = (occ_q != 2'd0);

    // Pop first, then push into the slot left free, so push+pop keeps occupancy.
    always_comb begin
        e0_d    = e0_q;
        e1_d    = e1_q;
        occ_pop = occ_q;
        if (pop_ok) begin
            e0_d    = e1_q;
            occ_pop = occ_q - 2'd1;
        end
        occ_d = occ_pop;
        if (push && (occ_pop < 2'(SKID_DEPTH))) begin
            if (occ_pop == 2'd0) begin
                e0_d = push_data;
            end else begin
                e1_d = push_data;
            end
            occ_d = occ_pop + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e0_q  <= '0;
            e1_q  <= '0;
            occ_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            occ_q <= occ_d;
        end
    end

endmodule

// File: rtl/bram_stream_reader.sv
// Burst read sequencer: issues RAM reads and streams the words out with backpressure.
// Optional feature macro: BRAM_READER_LAST_EN (m_last marks the final word of a burst).
module bram_stream_reader
    import bram_reader_pkg::*;
#(
    parameter int unsigned DW = DEFAULT_DW,
    parameter int unsigned AW = DEFAULT_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic          re,
    output logic [AW-1:0] raddr,
    input  logic [DW-1:0] rdata,
    output logic          m_valid,
    input  logic          m_ready,
`ifdef BRAM_READER_LAST_EN
    output logic          m_last,
`endif
    output logic [DW-1:0] m_data
);

`ifdef BRAM_READER_LAST_EN
    localparam int unsigned BW = DW + 1;
`else
    localparam int unsigned BW = DW;
`endif

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   remaining_q, remaining_d;
    logic          inflight_q;
    logic          done_q, done_d;
    logic [1:0]    occ;
    logic          pop;
    logic          head_valid;
    logic [BW-1:0] push_data, head_data;

    assign pop     = head_valid & m_ready;
    assign m_valid = head_valid;
    assign m_data  = head_data[DW-1:0];
    assign busy    = (state_q != StIdle);
    assign done    = done_q;
    assign raddr   = addr_q;

`ifdef BRAM_READER_LAST_EN
    logic inflight_last_q;
    assign push_data = {inflight_last_q, rdata};
    assign m_last    = head_data[DW];
`else
    assign push_data = rdata;
`endif

    // Only issue when the word is guaranteed a buffer slot, counting a pop this cycle.
    always_comb begin
        re = (state_q == StRun) && (remaining_q != '0) &&
             (({1'b0, occ} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d      = base_addr;
                    remaining_d = {1'b0, len} + (AW+1)'(1);
                    state_d     = StRun;
                end
            end
            StRun: begin
                if (re) begin
                    addr_d      = addr_q + AW'(1);
                    remaining_d = remaining_q - (AW+1)'(1);
                    if (remaining_q == (AW+1)'(1)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (!inflight_q && ((occ == 2'd0) || ((occ == 2'd1) && pop))) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            inflight_q  <= re;
            done_q      <= done_d;
        end
    end

`ifdef BRAM_READER_LAST_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_last_q <= 1'b0;
        end else begin
            inflight_last_q <= re && (remaining_q == (AW+1)'(1));
        end
    end
`endif

    bram_rd_skid #(
        .W (BW)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .push       (inflight_q),
        .push_data  (push_data),
        .pop        (pop),
        .occ        (occ),
        .head_data  (head_data),
        .head_valid (head_valid)
    );

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed self-checking bench for bram_stream_reader with a registered-output RAM model.
// Compile with +define+BRAM_READER_LAST_EN to also check m_last.
module tb_bram_stream_reader;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] len = '0;
    logic          busy, done, re, m_valid;
    logic          m_ready = 1'b1;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata = '0;
    logic [DW-1:0] m_data;
`ifdef BRAM_READER_LAST_EN
    logic          m_last;
`endif

    logic [DW-1:0] mem [256];

    int checks = 0;
    int errors = 0;
    int first_re, last_re, first_beat, last_beat, done_at, n_done;
    logic [DW-1:0] first_data, last_data;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (re) rdata <= mem[raddr];
    end

    bram_stream_reader #(
        .DW (DW),
        .AW (AW)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .re        (re),
        .raddr     (raddr),
        .rdata     (rdata),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
`ifdef BRAM_READER_LAST_EN
        .m_last    (m_last),
`endif
        .m_data    (m_data)
    );

    function automatic logic [DW-1:0] exp_word(input int a);
        return 16'((a & 255) * 3);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_check();
        @(negedge clk);
        #1;
        check("done_single_cycle", done, 0);
        check("idle_busy", busy, 0);
    endtask

    // Runs one burst, checking addresses, data order, stall stability and issue room.
    task automatic run_burst(input logic [7:0] b, input logic [7:0] l, input logic [7:0] pat,
                             input bit skip_start, input bit inject_busy, input int abort_beats,
                             input bit chain, input logic [7:0] nb, input logic [7:0] nl);
        int n = int'(l) + 1;
        int issued = 0;
        int beats = 0;
        int k = 0;
        bit hs;
        bit prev_stall = 1'b0;
        bit finished = 1'b0;
        logic [DW-1:0] prev_data = '0;
        first_re = -1; last_re = -1; first_beat = -1; last_beat = -1;
        done_at = -1; n_done = 0;
        if (!skip_start) begin
            @(negedge clk);
            start = 1'b1; base_addr = b; len = l;
        end
        while (!finished && k < 2000) begin
            @(negedge clk);
            k++;
            start = 1'b0;
            m_ready = pat[k % 8];
            if (inject_busy && k == 3) begin
                start = 1'b1; base_addr = 8'hAA; len = 8'h05;
            end
            #1;
            if (k == 1) begin
                check("busy_after_start", busy, 1);
                check("done_clear", done, 0);
            end
            hs = m_valid && m_ready;
            check("occ_le2", 32'(u_dut.occ <= 2'd2), 1);
            if (re) begin
                check("re_room", 32'((issued - beats - int'(hs)) < 2), 1);
                check("raddr", 32'(raddr), (int'(b) + issued) & 255);
                if (first_re < 0) first_re = k;
                last_re = k;
                issued++;
            end
            if (prev_stall) begin
                check("stall_valid", m_valid, 1);
                check("stall_data", m_data, prev_data);
            end
            if (hs) begin
                check("data", m_data, exp_word(int'(b) + beats));
`ifdef BRAM_READER_LAST_EN
                check("m_last", m_last, 32'(beats == n - 1));
`endif
                if (first_beat < 0) begin
                    first_beat = k;
                    first_data = m_data;
                end
                last_beat = k;
                last_data = m_data;
                beats++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data = m_data;
            if (done) begin
                n_done++;
                done_at = k;
                check("done_beats", beats, n);
                check("done_issued", issued, n);
                check("done_busy", busy, 0);
                finished = 1'b1;
                if (chain) begin
                    start = 1'b1; base_addr = nb; len = nl;
                end
            end
            if (abort_beats != 0 && beats == abort_beats) begin
                rst = 1'b1;
                finished = 1'b1;
            end
        end
        if (!finished) check("timeout", 0, 1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'(i * 3);

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_re", re, 0);
        check("rst_raddr", 32'(raddr), 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
`ifdef BRAM_READER_LAST_EN
        check("rst_m_last", m_last, 0);
`endif
        rst = 1'b0;

        // Full-throughput burst
        run_burst(8'h10, 8'd3, 8'hFF, 1'b0, 1'b0, 0, 1'b0, 8'h00, 8'h00);
        check("t1_first_latency", first_beat - first_re, 2);
        check("t1_re_back2back", last_re - first_re, 3);
        check("t1_beats_back2back", last_beat - first_beat, 3);
        check("t1_done_after_last", done_at - last_beat, 1);
        check("t1_first_data", first_data, 16'h0030);
        check("t1_last_data", last_data, 16'h0039);
        idle_check();

        // Address wrap
        run_burst(8'hFE, 8'd3, 8'hFF, 1'b0, 1'b0, 0, 1'b0, 8'h00, 8'h00);
        check("t2_first_data", first_data, 16'h02FA);
        check("t2_last_data", last_data, 16'h0003);
        check("t2_done_once", n_done, 1);
        idle_check();

        // Backpressure pattern 1,0,0,1,0,1,1,1 plus a start while busy
        run_burst(8'h00, 8'd7, 8'hE9, 1'b0, 1'b1, 0, 1'b0, 8'h00, 8'h00);
        check("t3_first_data", first_data, 16'h0000);
        check("t3_last_data", last_data, 16'h0015);
        idle_check();

        // Single word
        run_burst(8'h80, 8'd0, 8'hFF, 1'b0, 1'b0, 0, 1'b0, 8'h00, 8'h00);
        check("t4_single_re", last_re - first_re, 0);
        check("t4_single_data", last_data, 16'h0180);
        idle_check();

        // Maximum length, then a new start in the done cycle
        run_burst(8'h37, 8'd255, 8'hFF, 1'b0, 1'b0, 0, 1'b1, 8'h20, 8'd2);
        check("t4_max_last_data", last_data, 16'h00A2);
        run_burst(8'h20, 8'd2, 8'hFF, 1'b1, 1'b0, 0, 1'b0, 8'h00, 8'h00);
        check("t5_chain_first", first_data, 16'h0060);
        check("t5_chain_last", last_data, 16'h0066);
        idle_check();

        // Reset after two beats
        run_burst(8'h00, 8'd7, 8'hFF, 1'b0, 1'b0, 2, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        #1;
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        check("t6_re", re, 0);
        check("t6_raddr", 32'(raddr), 0);
        check("t6_m_valid", m_valid, 0);
        check("t6_m_data", m_data, 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check("t6_no_done", done, 0);
        end
        run_burst(8'h40, 8'd1, 8'hFF, 1'b0, 1'b0, 0, 1'b0, 8'h00, 8'h00);
        check("t6_first_data", first_data, 16'h00C0);
        check("t6_last_data", last_data, 16'h00C3);
        idle_check();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
